// File: rtl/demux_lanes.sv
// ---------------------------------------------------------------------------
// demux_lanes
//
// Splits a single muxed word stream into two lane FIFOs. Successive valid
// words alternate between lane 0 and lane 1 through a shared selector,
// and each lane is drained independently through its own pop request. Read
// data is registered, so a pop at edge N presents its word after edge N.
// If a word arrives for a full lane that is not popped in the same cycle,
// the word is dropped and a sticky error flag is raised.
//
// Parameters
//   DATA_WIDTH  width of every data port and FIFO entry
//   DEPTH       entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk                       single clock, all state changes on posedge
//   reset_L                   synchronous active-low reset
//   data_in / valid_in        incoming muxed word and its qualifier
//   pop_0 / pop_1             read request for each lane head
//   data_out_0 / data_out_1   registered read data per lane
//   valid_out_0 / valid_out_1 read data was refreshed by the previous edge
//   empty_0 / empty_1         lane holds no entries
//   full_0 / full_1           lane holds DEPTH entries
//   sel_out                   lane that the next valid word will go to
//   error_out                 sticky overflow flag, cleared only by reset
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux_lanes_fifo
//
// One lane: a circular buffer with its own occupancy count and a registered
// read port.
//
// Ports
//   clk, reset_L   clock and synchronous active-low reset
//   push           a word is targeted at this lane this cycle
//   pop            read request for the head entry
//   data_in        word to store on push
//   data_out       registered head entry from the last successful pop
//   valid_out      data_out was refreshed by the previous edge
//   empty, full    occupancy decode of the registered count
// ---------------------------------------------------------------------------
module demux_lanes_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_pop;
    logic                  do_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop on an empty lane is ignored even if a word is arriving in the
    // same cycle: there is no write-to-read bypass.
    assign do_pop  = pop && !empty;

    // A full lane can still accept a word when its head leaves in the
    // same cycle; the freed slot is the one being written.
    assign do_push = push && (!full || do_pop);

    // Storage is not cleared by reset; the pointers and count alone define
    // which entries are live.
    always_ff @(posedge clk) begin
        if (reset_L && do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally through their AW-bit width.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            valid_out <= do_pop;
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module demux_lanes #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop_0,
    input  logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_out_0,
    output logic                  valid_out_1,
    output logic                  empty_0,
    output logic                  empty_1,
    output logic                  full_0,
    output logic                  full_1,
    output logic                  sel_out,
    output logic                  error_out
);

    logic sel;
    logic push_0;
    logic push_1;
    logic drop;
    logic error_q;

    assign push_0 = valid_in && !sel;
    assign push_1 = valid_in &&  sel;

    // A word is lost only when its lane is full and nothing leaves that
    // lane in the same cycle (a full lane is never empty, so pop succeeds).
    assign drop = (push_0 && full_0 && !pop_0) ||
                  (push_1 && full_1 && !pop_1);

    // The selector advances on every valid word, dropped or not, so the
    // lane assignment depends only on the position in the input stream.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sel     <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (valid_in) begin
                sel <= ~sel;
            end
            if (drop) begin
                error_q <= 1'b1;
            end
        end
    end

    assign sel_out   = sel;
    assign error_out = error_q;

    demux_lanes_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane_0 (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push_0),
        .pop       (pop_0),
        .data_in   (data_in),
        .data_out  (data_out_0),
        .valid_out (valid_out_0),
        .empty     (empty_0),
        .full      (full_0)
    );

    demux_lanes_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane_1 (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push_1),
        .pop       (pop_1),
        .data_in   (data_in),
        .data_out  (data_out_1),
        .valid_out (valid_out_1),
        .empty     (empty_1),
        .full      (full_1)
    );

endmodule

// File: doc/demux_lanes.md
DEMUX_LANES -- requirements
Module: demux_lanes

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of every data port and FIFO entry.
REQ-002 Parameter DEPTH, default 4, entries per lane FIFO; power of two.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_L  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 data_in  input  DATA_WIDTH  muxed data word from upstream mux stage.
REQ-006 valid_in  input  1  data_in carries a word this cycle.
REQ-007 pop_0  input  1  request read of lane 0 head entry.
REQ-008 pop_1  input  1  request read of lane 1 head entry.
REQ-009 data_out_0  output  DATA_WIDTH  registered lane 0 read data.
REQ-010 data_out_1  output  DATA_WIDTH  registered lane 1 read data.
REQ-011 valid_out_0  output  1  data_out_0 updated by a successful pop in the previous cycle.
REQ-012 valid_out_1  output  1  data_out_1 updated by a successful pop in the previous cycle.
REQ-013 empty_0 / empty_1  output  1 each  lane FIFO holds 0 entries.
REQ-014 full_0 / full_1  output  1 each  lane FIFO holds DEPTH entries.
REQ-015 sel_out  output  1  lane the next valid_in word will be steered to.
REQ-016 error_out  output  1  sticky overflow flag.

Function
REQ-017 Internal lane selector sel SHALL reset to 0 and toggle on every posedge where valid_in=1, regardless of FIFO state; sel_out = sel.
REQ-018 valid_in=1 with target lane not full (or full with same-cycle pop on that lane) SHALL write data_in at that lane's write pointer.
REQ-019 valid_in=1 with target lane full and no pop on that lane SHALL drop the word, leave the FIFO unchanged, and set error_out=1.
REQ-020 error_out SHALL stay 1 until reset; no other event clears it.
REQ-021 pop_n=1 with lane n not empty SHALL load head entry into data_out_n and set valid_out_n=1 at the same edge; read pointer advances.
REQ-022 pop_n=1 with lane n empty SHALL be ignored: data_out_n holds, valid_out_n=0, no error.
REQ-023 valid_out_n SHALL be 0 on any cycle following an edge without a successful pop on lane n; data_out_n holds its last value.
REQ-024 Per-lane occupancy count 0..DEPTH (log2(DEPTH)+1 bits): +1 on write only, -1 on pop only, unchanged on write+pop.
REQ-025 Read/write pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0 with no special handling.
REQ-026 empty_n = (count_n==0), full_n = (count_n==DEPTH), decoded combinationally from registered count.
REQ-027 Latency: word written at edge N is visible (empty_n=0) after edge N; earliest pop at edge N+1; data_out_n valid after edge N+1.
REQ-028 Push into an empty lane with same-cycle pop SHALL NOT bypass; pop is ignored per REQ-022, push completes.
REQ-029 Lanes SHALL be fully independent apart from the shared sel.

Reset
REQ-030 reset_L=0 at a posedge SHALL set sel=0, both counts and all pointers 0, data_out_0/1=0, valid_out_0/1=0, error_out=0; empty_0/1=1, full_0/1=0.
REQ-031 Reset mid-operation SHALL discard all FIFO contents; pops and valid_in in the reset cycle are ignored.
REQ-032 FIFO storage array need not be cleared by reset.

Verification
REQ-033 Reset, then valid_in=1 with data_in 0x1,0xE,0x2,0xD on 4 edges -> lane0 holds 0x1,0x2; lane1 holds 0xE,0xD; sel_out=0; error_out=0.
REQ-034 Pop both lanes twice from REQ-033 state -> data_out_0 0x1 then 0x2, data_out_1 0xE then 0xD, valid_out 1 for 2 cycles then 0; both empty=1.
REQ-035 10 consecutive valid words 0x0..0x9, no pops -> after word 8 both full=1; words 0x8,0x9 dropped; error_out=1 and stays 1.
REQ-036 Lane0 full, valid_in to lane0 with pop_0 same edge -> data_out_0=old head, new word accepted, full_0 stays 1, error_out stays 0.
REQ-037 pop_0 on empty lane0 -> valid_out_0=0, data_out_0 unchanged, error_out=0.
REQ-038 3 words in lane0, reset_L=0 one edge with pop_0=1 -> empty_0=1, valid_out_0=0, sel_out=0; next pop_0 yields valid_out_0=0.
